// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if: command port and AHB-lite bus signals of the ahb_lite_master block
interface ahb_lite_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic        cmd_burst;
  logic [31:0] wr_data;
  logic        wr_pop;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, wr_data, HRDATA, HREADY, HRESP,
    output cmd_ready, wr_pop, rd_valid, rd_data, done, err,
           HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, wr_data, HRDATA, HREADY, HRESP,
    input  cmd_ready, wr_pop, rd_valid, rd_data, done, err,
           HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HWDATA
  );
endinterface

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: AHB-lite master running SINGLE commands, plus INCR4 bursts when AHB_MASTER_INCR4_EN is defined
module ahb_lite_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic HCLK,
  input logic HRESET,
  ahb_lite_master_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  logic [1:0]  state;
  logic [1:0]  htrans;
  logic [1:0]  beats_left;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] rd_data;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        wr_pop;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic        burst;
  logic        err_first;
  logic [31:0] inc;
`ifdef AHB_MASTER_INCR4_EN
  assign burst = bus.cmd_burst;
`else
  logic unused_burst;
  assign unused_burst = bus.cmd_burst;
  assign burst = 1'b0;
`endif
  assign inc       = 32'd1 << hsize;
  assign err_first = state == DATA && bus.HRESP && !bus.HREADY;
  assign bus.cmd_ready = HRESET && state == IDLE;
  assign bus.HTRANS    = err_first ? TR_IDLE : htrans;
  assign bus.HADDR     = haddr;
  assign bus.HWRITE    = hwrite;
  assign bus.HSIZE     = hsize;
  assign bus.HBURST    = hburst;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HWDATA    = hwdata;
  assign bus.wr_pop    = wr_pop;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = rd_data;
  assign bus.done      = done;
  assign bus.err       = err;
  // command sequencing: address phase of the next beat overlaps the data phase of the current one
  always_ff @(posedge HCLK or negedge HRESET)
    if (!HRESET) begin
      state      <= IDLE;
      htrans     <= TR_IDLE;
      beats_left <= 2'd0;
      haddr      <= 32'd0;
      hwdata     <= 32'd0;
      rd_data    <= 32'd0;
      hwrite     <= 1'b0;
      hsize      <= 3'd0;
      hburst     <= 3'd0;
      wr_pop     <= 1'b0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_pop   <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      if (state == IDLE) begin
        if (bus.cmd_valid) begin
          state      <= ADDR;
          htrans     <= TR_NONSEQ;
          haddr      <= bus.cmd_addr;
          hwrite     <= bus.cmd_write;
          hsize      <= bus.cmd_size > 3'd2 ? 3'd2 : bus.cmd_size;
          hburst     <= burst ? 3'b011 : 3'b000;
          beats_left <= burst ? 2'd3 : 2'd0;
        end
      end else if (state == ERR) begin
        if (bus.HREADY) begin
          state <= IDLE;
          done  <= 1'b1;
          err   <= 1'b1;
        end
      end else if (err_first) begin
        state  <= ERR;
        htrans <= TR_IDLE;
      end else if (state == DATA && bus.HRESP && bus.HREADY) begin
        state  <= IDLE;
        htrans <= TR_IDLE;
        done   <= 1'b1;
        err    <= 1'b1;
      end else if (bus.HREADY) begin
        if (state == DATA && !hwrite) begin
          rd_valid <= 1'b1;
          rd_data  <= bus.HRDATA;
        end
        if (htrans != TR_IDLE) begin
          state      <= DATA;
          htrans     <= beats_left != 2'd0 ? TR_SEQ : TR_IDLE;
          haddr      <= beats_left != 2'd0 ? haddr + inc : haddr;
          beats_left <= beats_left != 2'd0 ? beats_left - 2'd1 : 2'd0;
          if (hwrite) begin
            hwdata <= bus.wr_data;
            wr_pop <= 1'b1;
          end
        end else begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: randomized bench for ahb_lite_master against a beat-level transaction model
module tb_ahb_lite_master;
`ifdef AHB_MASTER_INCR4_EN
  localparam bit incr4_en = 1'b1;
`else
  localparam bit incr4_en = 1'b0;
`endif
  logic HCLK;
  logic HRESET;
  ahb_lite_master_if bus();
  ahb_lite_master dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));
  int checks = 0;
  int errors = 0;
  int n, issued, completed, eb, wb, hold;
  bit wr, inj, aborted, finished, exp_done, exp_err, exp_rdv, new_dp, stall;
  logic [31:0] ea [4];
  logic [31:0] w [4];
  logic [31:0] exp_rdata, cur_hrdata;
  logic [2:0] sz, hb;
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic model_edge();
    bit dp, comp;
    dp = issued > completed && !finished;
    comp = 1'b0;
    exp_done = 1'b0;
    exp_rdv = 1'b0;
    new_dp = 1'b0;
    if (dp && bus.HRESP && bus.HREADY) begin
      exp_done = 1'b1;
      exp_err = 1'b1;
      finished = 1'b1;
    end else if (dp && bus.HREADY && !bus.HRESP) begin
      completed++;
      comp = 1'b1;
      if (!wr) begin
        exp_rdv = 1'b1;
        exp_rdata = cur_hrdata;
      end
    end
    if (!finished && !aborted && issued < n && bus.HREADY) begin
      issued++;
      new_dp = 1'b1;
    end
    if (comp && completed == n) begin
      exp_done = 1'b1;
      exp_err = 1'b0;
      finished = 1'b1;
    end
  endtask
  task automatic slave_drive();
    bit dp;
    dp = issued > completed && !finished;
    cur_hrdata = $urandom;
    bus.HRDATA = cur_hrdata;
    bus.HRESP = 1'b0;
    if (issued < n) bus.wr_data = w[issued];
    else bus.wr_data = $urandom;
    if (dp && inj && completed == eb) begin
      bus.HRESP = 1'b1;
      bus.HREADY = aborted;
      aborted = 1'b1;
    end else if (dp && completed == wb && hold > 0) begin
      bus.HREADY = 1'b0;
      hold--;
    end else begin
      bus.HREADY = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask
  task automatic cycle_check();
    bit act;
    act = issued < n && !aborted && !finished;
    check("htrans", 128'(bus.HTRANS), 128'(act ? (issued == 0 ? 2'b10 : 2'b11) : 2'b00));
    if (act) check("addr_ctrl", 128'({bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HBURST}), 128'({ea[issued], wr, sz, hb}));
    check("wr_pop", 128'(bus.wr_pop), 128'(new_dp && wr));
    if (wr && issued > completed && !finished) check("hwdata", 128'(bus.HWDATA), 128'(w[completed]));
    check("rd_valid", 128'(bus.rd_valid), 128'(exp_rdv));
    if (exp_rdv) check("rd_data", 128'(bus.rd_data), 128'(exp_rdata));
    check("done", 128'(bus.done), 128'(exp_done));
    if (exp_done) check("err", 128'(bus.err), 128'(exp_err));
    check("cmd_ready", 128'(bus.cmd_ready), 128'(finished));
  endtask
  task automatic run_cmd(input bit cw, input logic [31:0] ca, input logic [2:0] cs, input bit cb,
                         input bit ci, input int ce, input bit cst, input int cwb, input logic [31:0] d0);
    wr = cw;
    n = (cb && incr4_en) ? 4 : 1;
    sz = cs > 3'd2 ? 3'd2 : cs;
    hb = n == 4 ? 3'b011 : 3'b000;
    for (int i = 0; i < 4; i++) begin
      ea[i] = ca + (32'(i) << sz);
      w[i] = $urandom;
    end
    w[0] = d0;
    inj = ci && ce < n;
    eb = ce;
    stall = cst;
    wb = cwb;
    hold = 2;
    issued = 0;
    completed = 0;
    aborted = 1'b0;
    finished = 1'b0;
    exp_done = 1'b0;
    exp_rdv = 1'b0;
    new_dp = 1'b0;
    check("ready_idle", 128'(bus.cmd_ready), 128'(1'b1));
    bus.cmd_valid = 1'b1;
    bus.cmd_write = cw;
    bus.cmd_addr = ca;
    bus.cmd_size = cs;
    bus.cmd_burst = cb;
    bus.wr_data = w[0];
    @(posedge HCLK);
    #1 bus.cmd_valid = 1'b0;
    slave_drive();
    @(negedge HCLK);
    cycle_check();
    for (int c = 0; c < 200 && !finished; c++) begin
      @(posedge HCLK);
      model_edge();
      #1 slave_drive();
      @(negedge HCLK);
      cycle_check();
    end
    check("finished", 128'(finished), 128'(1'b1));
  endtask
  function automatic logic [127:0] all_outs();
    return 128'({bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HWRITE, bus.HSIZE, bus.HBURST,
                 bus.wr_pop, bus.rd_valid, bus.done, bus.err, bus.rd_data, bus.cmd_ready});
  endfunction
  initial begin
    HRESET = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 32'd0;
    bus.cmd_size = 3'd0;
    bus.cmd_burst = 1'b0;
    bus.wr_data = 32'd0;
    bus.HRDATA = 32'd0;
    bus.HREADY = 1'b1;
    bus.HRESP = 1'b0;
    repeat (3) @(negedge HCLK);
    check("reset_outs", all_outs(), 128'(0));
    HRESET = 1'b1;
    @(negedge HCLK);
    check("ready_after_reset", 128'(bus.cmd_ready), 128'(1'b1));
    check("hprot", 128'(bus.HPROT), 128'(4'b0011));
    run_cmd(1'b1, 32'h100, 3'd2, 1'b0, 1'b0, 0, 1'b0, -1, 32'hDEADBEEF);
    run_cmd(1'b0, 32'h200, 3'd2, 1'b1, 1'b0, 0, 1'b0, -1, $urandom);
    run_cmd(1'b1, 32'h10, 3'd1, 1'b1, 1'b0, 0, 1'b0, 1, $urandom);
    run_cmd(1'b0, 32'h300, 3'd2, 1'b1, 1'b1, 1, 1'b0, -1, $urandom);
    run_cmd(1'b0, 32'h40, 3'd0, 1'b0, 1'b1, 0, 1'b0, -1, $urandom);
    run_cmd(1'b1, 32'h80, 3'd7, 1'b1, 1'b0, 0, 1'b1, -1, $urandom);
    for (int k = 0; k < 40; k++)
      run_cmd(1'($urandom), $urandom, 3'($urandom_range(0, 7)), 1'($urandom),
              $urandom_range(0, 4) == 0, $urandom_range(0, 3), 1'b1,
              $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 3)) : -1, $urandom);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 32'h400;
    bus.cmd_size = 3'd2;
    bus.cmd_burst = 1'b1;
    bus.HREADY = 1'b1;
    bus.HRESP = 1'b0;
    @(posedge HCLK);
    #1 bus.cmd_valid = 1'b0;
    repeat (2) @(posedge HCLK);
    #2 HRESET = 1'b0;
    #1 check("reset_mid_outs", all_outs(), 128'(0));
    @(negedge HCLK);
    HRESET = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      check("post_reset_done", 128'(bus.done), 128'(1'b0));
      check("post_reset_ready", 128'(bus.cmd_ready), 128'(1'b1));
      check("post_reset_htrans", 128'(bus.HTRANS), 128'(2'b00));
    end
    run_cmd(1'b0, 32'h500, 3'd2, 1'b0, 1'b0, 0, 1'b1, -1, $urandom);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 Parameter HPROT_VAL, default 4'b0011, is the constant value driven on HPROT.
REQ-002 HCLK  in  1  bus clock; all state changes on its rising edge.
REQ-003 HRESET  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-006 cmd_write  in  1  1=write, 0=read.
REQ-007 cmd_addr  in  32  start address.
REQ-008 cmd_size  in  3  transfer size, 0=byte, 1=half, 2=word.
REQ-009 cmd_burst  in  1  1=INCR4, 0=SINGLE.
REQ-010 wr_data  in  32  write data for the next write beat.
REQ-011 wr_pop  out  1  one-cycle pulse: wr_data captured for a beat.
REQ-012 rd_valid  out  1  one-cycle pulse: rd_data holds a completed read beat.
REQ-013 rd_data  out  32  read beat data.
REQ-014 done  out  1  one-cycle pulse: command finished.
REQ-015 err  out  1  valid with done: 1 if any beat received an ERROR response.
REQ-016 HADDR, HWRITE, HSIZE[2:0], HBURST[2:0], HTRANS[1:0], HPROT[3:0], HWDATA[31:0]  out: AHB-lite address/control/write-data.
REQ-017 HRDATA[31:0], HREADY, HRESP  in: AHB-lite read data, ready, response.

Function
REQ-018 States: IDLE, ADDR, DATA, ERR; cmd_ready SHALL be 1 only in IDLE.
REQ-019 On cmd_valid&&cmd_ready, the command SHALL be latched and the next cycle SHALL be ADDR, with HTRANS=NONSEQ, HADDR=cmd_addr, HWRITE, HSIZE, and HBURST=INCR4 (3'b011) or SINGLE (3'b000).
REQ-020 cmd_size>2 SHALL be driven as HSIZE=2.
REQ-021 An address phase SHALL complete on a rising edge with HREADY=1; until then all address/control outputs SHALL hold.
REQ-022 On completion of the address phase, the beat SHALL enter its data phase; for a write, wr_data SHALL be registered onto HWDATA and wr_pop SHALL pulse in that same cycle.
REQ-023 INCR4 beats 2-4 SHALL issue HTRANS=SEQ with HADDR = previous + (1<<HSIZE), overlapped with the previous beat's data phase; there is no wrap and no 1KB-boundary check (caller responsibility).
REQ-024 After the last address phase, HTRANS SHALL be IDLE (2'b00) while the final data phase completes.
REQ-025 For a read, a data phase completing with HREADY=1 and HRESP=0 SHALL register HRDATA to rd_data and pulse rd_valid on the next cycle.
REQ-026 HRESP=1 with HREADY=0 (first ERROR cycle) SHALL drive HTRANS=IDLE immediately, cancel remaining beats, and enter ERR.
REQ-027 ERR SHALL wait for HREADY=1, then pulse done with err=1 and return to IDLE; rd_valid SHALL NOT pulse for the errored beat.
REQ-028 Normal completion of the final data phase SHALL pulse done with err=0 one cycle later and return to IDLE.
REQ-029 Latency for a zero-wait SINGLE: handshake at edge 0, NONSEQ during cycle 1, data phase during cycle 2, done/rd_valid high during cycle 3.
REQ-030 BUSY SHALL never be issued.

Reset
REQ-031 While HRESET=0: state=IDLE; HTRANS=0, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, HBURST=0; wr_pop, rd_valid, done and err=0; rd_data=0. cmd_ready SHALL be 0 during reset and 1 after release.
REQ-032 Reset asserted mid-transfer SHALL abort immediately with no done pulse.

Configuration
REQ-033 Macro AHB_MASTER_INCR4_EN defined: INCR4 behaves per REQ-023; undefined: cmd_burst is ignored, and every command is SINGLE with HBURST=0.

Verification
REQ-034 SINGLE write: addr 0x100, data 0xDEADBEEF, size 2, HREADY=1 -> NONSEQ at 0x100, HWDATA=0xDEADBEEF in the next cycle, done with err=0.
REQ-035 INCR4 read from 0x200, size 2 -> HADDR 0x200/0x204/0x208/0x20C with NONSEQ,SEQ,SEQ,SEQ; four rd_valid pulses; done with err=0.
REQ-036 INCR4 write, size 1, from 0x10, with HREADY low for 2 cycles on beat 2 -> addresses 0x10/0x12/0x14/0x16; control held during the wait; four wr_pop pulses.
REQ-037 Read at 0x300 with a 2-cycle ERROR response on beat 2 of INCR4 -> HTRANS=IDLE in the first ERROR cycle; 1 rd_valid; done with err=1; no further beats.
REQ-038 HRESET low during beat 3 of INCR4 -> all outputs are 0 in the same cycle; after release, cmd_ready=1 and no done pulse.
REQ-039 Build without AHB_MASTER_INCR4_EN, cmd_burst=1 -> a single NONSEQ with HBURST=0 and one done pulse.
